// File: rtl/knn_list_pkg.sv
// Shared types and helpers for the k-nearest-neighbour sorted list.
package knn_list_pkg;

    // Controller states shared with the distance unit and top-level sequencer
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StDone    = 2'd2
    } knn_state_e;

    // Index width that never collapses to zero bits (K=1 still needs a port bit)
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/knn_list_slot.sv
// One entry of the sorted list: distance/id/valid registers, the strict-less
// compare against the incoming sample, and the load-new vs shift-from-upper mux.
module knn_list_slot #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_load_new,
    input  logic              i_load_upper,
    input  logic [DATA_W-1:0] i_new_dist,
    input  logic [ID_W-1:0]   i_new_id,
    input  logic [DATA_W-1:0] i_up_dist,
    input  logic [ID_W-1:0]   i_up_id,
    input  logic              i_up_valid,
    output logic [DATA_W-1:0] o_dist,
    output logic [ID_W-1:0]   o_id,
    output logic              o_valid,
    output logic              o_lt
);

    logic [DATA_W-1:0] r_dist;
    logic [ID_W-1:0]   r_id;
    logic              r_valid;

    // Entry storage: clear empties, new sample wins over a shift from the nearer slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dist  <= '0;
            r_id    <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_dist  <= '0;
            r_id    <= '0;
            r_valid <= 1'b0;
        end else if (i_load_new) begin
            r_dist  <= i_new_dist;
            r_id    <= i_new_id;
            r_valid <= 1'b1;
        end else if (i_load_upper) begin
            r_dist  <= i_up_dist;
            r_id    <= i_up_id;
            r_valid <= i_up_valid;
        end
    end

    // Strict compare keeps earlier arrivals ahead on ties; empty slots always accept
    always_comb begin
        o_lt = !r_valid || (i_new_dist < r_dist);
    end

    assign o_dist  = r_dist;
    assign o_id    = r_id;
    assign o_valid = r_valid;

endmodule

// File: rtl/knn_list.sv
// Sorted list of the NBR_KNN nearest samples for the current test point,
// with sample counter, collect/done FSM, overflow flag and a random-access read port.
module knn_list
    import knn_list_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NBR_KNN   = 4,
    parameter int unsigned NBR_DATAP = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clear,
    input  logic                         i_en_list,
    input  logic [DATA_W-1:0]            i_distance,
    input  logic [DATA_W/4-1:0]          i_id,
    input  logic [idx_w(NBR_KNN)-1:0]    i_rd_idx,
    output logic [DATA_W-1:0]            o_rd_dist,
    output logic [DATA_W/4-1:0]          o_rd_id,
    output logic                         o_rd_valid,
    output logic [$clog2(NBR_KNN+1)-1:0] o_nbr_fill,
    output logic                         o_done,
    output logic                         o_overflow
);

    localparam int unsigned ID_W   = DATA_W / 4;
    localparam int unsigned RD_W   = idx_w(NBR_KNN);
    localparam int unsigned FILL_W = $clog2(NBR_KNN + 1);
    localparam int unsigned CNT_W  = $clog2(NBR_DATAP + 1);

    knn_state_e       r_state, w_state_d;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             w_accept;

    logic [DATA_W-1:0] w_dist    [NBR_KNN];
    logic [ID_W-1:0]   w_id      [NBR_KNN];
    logic [DATA_W-1:0] w_up_dist [NBR_KNN];
    logic [ID_W-1:0]   w_up_id   [NBR_KNN];
    logic [NBR_KNN-1:0] w_valid, w_up_valid, w_lt, w_load_new, w_load_upper;
    logic [FILL_W-1:0] w_fill;

    // clear has priority, so a coincident sample is never written
    assign w_accept = (r_state == StCollect) && i_en_list && !i_clear;

    // Priority encode: first lt slot takes the sample, every slot after it shifts down
    always_comb begin
        logic w_seen;
        w_seen       = 1'b0;
        w_load_new   = '0;
        w_load_upper = '0;
        for (int k = 0; k < NBR_KNN; k++) begin
            w_load_new[k]   = w_accept && w_lt[k] && !w_seen;
            w_load_upper[k] = w_accept && w_seen;
            w_seen          = w_seen || w_lt[k];
        end
    end

    for (genvar g = 0; g < NBR_KNN; g++) begin : g_slot
        if (g == 0) begin : g_head
            assign w_up_dist[g]  = '0;
            assign w_up_id[g]    = '0;
            assign w_up_valid[g] = 1'b0;
        end else begin : g_tail
            assign w_up_dist[g]  = w_dist[g-1];
            assign w_up_id[g]    = w_id[g-1];
            assign w_up_valid[g] = w_valid[g-1];
        end

        knn_list_slot #(
            .DATA_W (DATA_W),
            .ID_W   (ID_W)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .i_clear      (i_clear),
            .i_load_new   (w_load_new[g]),
            .i_load_upper (w_load_upper[g]),
            .i_new_dist   (i_distance),
            .i_new_id     (i_id),
            .i_up_dist    (w_up_dist[g]),
            .i_up_id      (w_up_id[g]),
            .i_up_valid   (w_up_valid[g]),
            .o_dist       (w_dist[g]),
            .o_id         (w_id[g]),
            .o_valid      (w_valid[g]),
            .o_lt         (w_lt[g])
        );
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state: clear restarts collection from anywhere; last accept freezes the list
    always_comb begin
        w_state_d = r_state;
        if (i_clear) begin
            w_state_d = StCollect;
        end else if (w_accept && (r_count == CNT_W'(NBR_DATAP - 1))) begin
            w_state_d = StDone;
        end
    end

    // Accepted-sample counter, includes samples dropped for being too far
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Sticky overflow: a sample arrived after the list was frozen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_overflow <= 1'b0;
        end else if ((r_state == StDone) && i_en_list) begin
            r_overflow <= 1'b1;
        end
    end

    // Read mux; indices beyond the list read as an empty slot
    always_comb begin
        o_rd_dist  = '0;
        o_rd_id    = '0;
        o_rd_valid = 1'b0;
        for (int k = 0; k < NBR_KNN; k++) begin
            if (i_rd_idx == RD_W'(k)) begin
                o_rd_dist  = w_dist[k];
                o_rd_id    = w_id[k];
                o_rd_valid = w_valid[k];
            end
        end
    end

    // Occupancy is the popcount of the valid bits
    always_comb begin
        w_fill = '0;
        for (int k = 0; k < NBR_KNN; k++) begin
            w_fill = w_fill + FILL_W'(w_valid[k]);
        end
    end

    assign o_nbr_fill = w_fill;
    assign o_done     = (r_state == StDone);
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_knn_list.sv
// Bench for knn_list: queue-based reference list checked every cycle, plus
// hand-computed expectations for the directed scenarios.
module tb_knn_list;

    localparam int DATA_W = 32;
    localparam int ID_W   = 8;
    localparam int K      = 4;
    localparam int NDP    = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              en_list = 1'b0;
    logic [DATA_W-1:0] distance = '0;
    logic [ID_W-1:0]   id = '0;
    logic [1:0]        rd_idx = '0;
    logic [DATA_W-1:0] rd_dist;
    logic [ID_W-1:0]   rd_id;
    logic              rd_valid;
    logic [2:0]        nbr_fill;
    logic              done;
    logic              overflow;

    int n_checks = 0;
    int n_errors = 0;

    knn_list #(
        .DATA_W    (DATA_W),
        .NBR_KNN   (K),
        .NBR_DATAP (NDP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (clear),
        .i_en_list  (en_list),
        .i_distance (distance),
        .i_id       (id),
        .i_rd_idx   (rd_idx),
        .o_rd_dist  (rd_dist),
        .o_rd_id    (rd_id),
        .o_rd_valid (rd_valid),
        .o_nbr_fill (nbr_fill),
        .o_done     (done),
        .o_overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: the K nearest samples kept as a sorted queue
    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [ID_W-1:0]   id;
    } ent_t;

    ent_t m_q[$];
    int   m_cnt = 0;
    bit   m_collecting = 0;
    bit   m_done = 0;
    bit   m_ovf = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_cnt = 0;
            m_collecting = 0;
            m_done = 0;
            m_ovf = 0;
        end else if (clear) begin
            m_q.delete();
            m_cnt = 0;
            m_collecting = 1;
            m_done = 0;
            m_ovf = 0;
        end else if (en_list) begin
            if (m_done) begin
                m_ovf = 1;
            end else if (m_collecting) begin
                int pos;
                ent_t e;
                pos = -1;
                for (int i = 0; i < m_q.size(); i++) begin
                    if (distance < m_q[i].d) begin
                        pos = i;
                        break;
                    end
                end
                if (pos < 0 && m_q.size() < K) pos = m_q.size();
                if (pos >= 0) begin
                    e.d  = distance;
                    e.id = id;
                    m_q.insert(pos, e);
                    if (m_q.size() > K) void'(m_q.pop_back());
                end
                m_cnt++;
                if (m_cnt == NDP) begin
                    m_done = 1;
                    m_collecting = 0;
                end
            end
        end
    end

    // Every cycle out of reset: sweep the read port and compare against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("nbr_fill", 64'(nbr_fill), 64'(m_q.size()));
            chk("done", 64'(done), 64'(m_done));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            for (int i = 0; i < K; i++) begin
                rd_idx = 2'(i);
                #1;
                chk("rd_valid", 64'(rd_valid), 64'(i < m_q.size()));
                chk("rd_dist", 64'(rd_dist), (i < m_q.size()) ? 64'(m_q[i].d) : 64'd0);
                chk("rd_id", 64'(rd_id), (i < m_q.size()) ? 64'(m_q[i].id) : 64'd0);
            end
        end
    end

    task automatic send(input int d, input int i);
        en_list  = 1'b1;
        distance = DATA_W'(d);
        id       = ID_W'(i);
        @(posedge clk);
        #1;
        en_list  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic pin_slot(input int s, input int d, input int i);
        chk("model dist", (s < m_q.size()) ? 64'(m_q[s].d) : 64'hffff, 64'(d));
        chk("model id", (s < m_q.size()) ? 64'(m_q[s].id) : 64'hffff, 64'(i));
    endtask

    int t5_d[NDP] = '{40, 5, 33, 5, 90, 12, 7, 61, 2, 18};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // IDLE ignores samples
        send(3, 1);
        chk("idle fill", 64'(nbr_fill), 64'd0);

        // T1: reset mid-collect clears everything immediately
        do_clear();
        send(11, 0);
        send(12, 1);
        send(13, 2);
        chk("t1 pre fill", 64'(nbr_fill), 64'd3);
        rst = 1'b1;
        #1;
        chk("t1 fill", 64'(nbr_fill), 64'd0);
        chk("t1 done", 64'(done), 64'd0);
        chk("t1 rd_valid", 64'(rd_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T2: out-of-order inserts
        do_clear();
        send(50, 0);
        send(20, 1);
        send(80, 2);
        send(10, 3);
        pin_slot(0, 10, 3);
        pin_slot(1, 20, 1);
        pin_slot(2, 50, 0);
        pin_slot(3, 80, 2);
        chk("t2 fill", 64'(nbr_fill), 64'd4);

        // T3: insert with eviction, then a too-far sample is dropped
        send(30, 4);
        send(90, 5);
        pin_slot(0, 10, 3);
        pin_slot(1, 20, 1);
        pin_slot(2, 30, 4);
        pin_slot(3, 50, 0);

        // T4: ties keep arrival order
        do_clear();
        send(7, 1);
        send(7, 2);
        pin_slot(0, 7, 1);
        pin_slot(1, 7, 2);
        chk("t4 fill", 64'(nbr_fill), 64'd2);

        // T5: done after NDP accepts, overflow afterwards, list frozen
        do_clear();
        for (int i = 0; i < NDP; i++) begin
            send(t5_d[i], i);
            if (i == NDP - 2) chk("t5 done early", 64'(done), 64'd0);
        end
        chk("t5 done", 64'(done), 64'd1);
        chk("t5 no ovf", 64'(overflow), 64'd0);
        send(1, 10);
        chk("t5 ovf", 64'(overflow), 64'd1);
        pin_slot(0, 2, 8);
        pin_slot(1, 5, 1);
        pin_slot(2, 5, 3);
        pin_slot(3, 7, 6);

        // T6: clear beats a coincident sample
        clear    = 1'b1;
        en_list  = 1'b1;
        distance = 32'd5;
        id       = 8'd9;
        @(posedge clk);
        #1;
        clear   = 1'b0;
        en_list = 1'b0;
        chk("t6 fill", 64'(nbr_fill), 64'd0);
        chk("t6 done", 64'(done), 64'd0);
        chk("t6 ovf", 64'(overflow), 64'd0);
        send(9, 4);
        chk("t6 refill", 64'(nbr_fill), 64'd1);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
